// File: rtl/apb_slave_pkg.sv
// Common types and constants for the APB register-file slave.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_t;

  // Byte addressing: the word index starts at this address bit.
  localparam int ADDR_LSB   = 2;
  // Wide enough for the largest supported wait-state count (15).
  localparam int WAIT_CNT_W = 4;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] next_v;
    if (value == ERR_CNT_MAX) begin
      next_v = value;
    end else begin
      next_v = value + 16'd1;
    end
    return next_v;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// Word array behind the APB slave: one synchronous write port, one
// combinational read port, cleared asynchronously by reset.
module apb_regfile_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             apb_clk,
  input  logic             sys_aresetn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data
);

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];

  // Store a word on write enable; reset wipes the whole array.
  always_ff @(posedge apb_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_idx} < DEPTH_W)) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Combinational read; indices past the array read as zero.
  always_comb begin
    if ({1'b0, rd_idx} < DEPTH_W) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/axilite_to_apb_define.svh
// Shared APB bus widths for the AXI-Lite to APB bridge and its slaves.
`ifndef AXILITE_TO_APB_DEFINE_SVH
`define AXILITE_TO_APB_DEFINE_SVH

`define AW_APB 32
`define DW_APB 32

`endif

// File: rtl/apb_slave_regfile.sv
// APB slave exposing a DEPTH-word register file with programmable wait
// states, address error reporting and a saturating error counter.
`include "axilite_to_apb_define.svh"

module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int AW_APB      = `AW_APB,
  parameter int DW_APB      = `DW_APB,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              apb_clk,
  input  logic              sys_aresetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AW_APB-1:0] paddr,
  input  logic [DW_APB-1:0] pwdata,
  output logic              pready,
  output logic [DW_APB-1:0] prdata,
  output logic              pslverr,
  output logic [15:0]       err_cnt
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = AW_APB - ADDR_LSB;

  localparam logic [WIDX_W-1:0]     DEPTH_W   = WIDX_W'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  apb_state_t              state_r;
  logic [WAIT_CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    write_r;
  logic                    err_r;
  logic [DW_APB-1:0]       wdata_r;
  logic                    pready_r;
  logic                    pslverr_r;
  logic [DW_APB-1:0]       prdata_r;
  logic [15:0]             err_cnt_r;

  logic                    setup_s;
  logic [WIDX_W-1:0]       word_idx_s;
  logic                    addr_err_s;
  logic [IDX_W-1:0]        rd_idx_s;
  logic                    rsp_write_s;
  logic                    rsp_err_s;
  logic [DW_APB-1:0]       rd_data_s;
  logic [DW_APB-1:0]       rsp_rdata_s;
  logic                    mem_we_s;

  // Decode the bus: setup-phase detection, word index and address legality.
  always_comb begin
    setup_s    = psel & ~penable;
    word_idx_s = paddr[AW_APB-1:ADDR_LSB];
    addr_err_s = (word_idx_s >= DEPTH_W) ||
                 (paddr[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}});
  end

  // Attributes of the response about to be loaded: the live bus when going
  // straight from IDLE (zero wait states), the latched copy from WAIT.
  always_comb begin
    if (state_r == IDLE) begin
      rd_idx_s    = word_idx_s[IDX_W-1:0];
      rsp_write_s = pwrite;
      rsp_err_s   = addr_err_s;
    end else begin
      rd_idx_s    = idx_r;
      rsp_write_s = write_r;
      rsp_err_s   = err_r;
    end
  end

  // Read data is only returned for clean reads; writes commit while the
  // response is on the bus and land at the edge that ends it.
  always_comb begin
    if (rsp_write_s || rsp_err_s) begin
      rsp_rdata_s = '0;
    end else begin
      rsp_rdata_s = rd_data_s;
    end
    mem_we_s = (state_r == RESP) && write_r && !pslverr_r;
  end

  // Transfer FSM with wait-state counter, registered response and error count.
  always_ff @(posedge apb_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      idx_r     <= '0;
      write_r   <= 1'b0;
      err_r     <= 1'b0;
      wdata_r   <= '0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
      err_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          // An access phase with no preceding setup phase is ignored here.
          if (setup_s) begin
            idx_r   <= word_idx_s[IDX_W-1:0];
            write_r <= pwrite;
            err_r   <= addr_err_s;
            wdata_r <= pwdata;
            cnt_r   <= WAIT_LOAD;
            if (WAIT_LOAD == {WAIT_CNT_W{1'b0}}) begin
              state_r   <= RESP;
              pready_r  <= 1'b1;
              pslverr_r <= rsp_err_s;
              prdata_r  <= rsp_rdata_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            // Master dropped the transfer: leave without side effects.
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (penable && (cnt_r == CNT_ONE)) begin
            state_r   <= RESP;
            cnt_r     <= '0;
            pready_r  <= 1'b1;
            pslverr_r <= rsp_err_s;
            prdata_r  <= rsp_rdata_s;
          end else if (cnt_r > CNT_ONE) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= '0;
          if (pslverr_r) begin
            err_cnt_r <= sat_inc16(err_cnt_r);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          pready_r  <= 1'b0;
          pslverr_r <= 1'b0;
          prdata_r  <= '0;
        end
      endcase
    end
  end

  apb_regfile_mem #(
    .DW    (DW_APB),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .apb_clk     (apb_clk),
    .sys_aresetn (sys_aresetn),
    .wr_en       (mem_we_s),
    .wr_idx      (idx_r),
    .wr_data     (wdata_r),
    .rd_idx      (rd_idx_s),
    .rd_data     (rd_data_s)
  );

  assign pready  = pready_r;
  assign pslverr = pslverr_r;
  assign prdata  = prdata_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: three instances (0, 3 and 5
// wait states) share one APB bus, with psel steered to the one under test.
module tb_apb_slave_regfile;

  logic        apb_clk = 1'b0;
  logic        sys_aresetn = 1'b0;
  logic        psel_b = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [1:0]  dsel = 2'd0;

  logic [2:0]  psel_v;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];
  logic [15:0] err_cnt_v [3];

  logic        pready_m;
  logic        pslverr_m;
  logic [31:0] prdata_m;
  logic [15:0] err_cnt_m;

  int          errs = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  // Reference model: word array and error count as seen by the bus master.
  logic [31:0] mem_m [64];
  int          err_m;

  always #5 apb_clk = ~apb_clk;

  always @(posedge apb_clk) cyc <= cyc + 1;

  assign psel_v[0] = psel_b & (dsel == 2'd0);
  assign psel_v[1] = psel_b & (dsel == 2'd1);
  assign psel_v[2] = psel_b & (dsel == 2'd2);

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regfile #(
      .AW_APB      (32),
      .DW_APB      (32),
      .DEPTH       (64),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .apb_clk     (apb_clk),
      .sys_aresetn (sys_aresetn),
      .psel        (psel_v[g]),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pready      (pready_v[g]),
      .prdata      (prdata_v[g]),
      .pslverr     (pslverr_v[g]),
      .err_cnt     (err_cnt_v[g])
    );
  end

  always_comb begin
    case (dsel)
      2'd1:    begin pready_m = pready_v[1]; pslverr_m = pslverr_v[1]; prdata_m = prdata_v[1]; err_cnt_m = err_cnt_v[1]; end
      2'd2:    begin pready_m = pready_v[2]; pslverr_m = pslverr_v[2]; prdata_m = prdata_v[2]; err_cnt_m = err_cnt_v[2]; end
      default: begin pready_m = pready_v[0]; pslverr_m = pslverr_v[0]; prdata_m = prdata_v[0]; err_cnt_m = err_cnt_v[0]; end
    endcase
  end

  task automatic tick();
    @(posedge apb_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
    err_m = 0;
  endtask

  // Expected outcome of one transfer, and the model update it implies.
  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] exp_rd, output logic exp_err);
    int unsigned widx;
    widx = addr / 4;
    exp_err = (widx >= 64) || (addr % 4 != 0);
    exp_rd = 32'h0;
    if (!wr && !exp_err) exp_rd = mem_m[widx];
    if (wr && !exp_err) mem_m[widx] = data;
    if (exp_err && err_m < 65535) err_m++;
  endtask

  task automatic do_reset();
    psel_b = 1'b0;
    penable = 1'b0;
    sys_aresetn = 1'b0;
    tick();
    tick();
    sys_aresetn = 1'b1;
    model_reset();
  endtask

  // One APB transfer starting now; ncyc = access cycle carrying pready (-1 on timeout).
  // stray flags any nonzero prdata/pslverr before pready or pready lasting >1 cycle.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output logic err, output int ncyc, output bit stray);
    stray = 1'b0;
    psel_b = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = data;
    tick();
    penable = 1'b1;
    ncyc = 1;
    while (pready_m !== 1'b1 && ncyc < 40) begin
      if (prdata_m !== 32'h0 || pslverr_m !== 1'b0) stray = 1'b1;
      tick();
      ncyc++;
    end
    rd = prdata_m;
    err = pslverr_m;
    if (pready_m !== 1'b1) ncyc = -1;
    tick();
    psel_b = 1'b0;
    penable = 1'b0;
    if (pready_m !== 1'b0 || prdata_m !== 32'h0 || pslverr_m !== 1'b0) stray = 1'b1;
  endtask

  task automatic test_reset();
    dsel = 2'd0;
    sys_aresetn = 1'b0;
    tick();
    checks++; if (pready_m !== 1'b0) begin errs++; $display("FAIL reset_pready: got %b expected 0", pready_m); end
    checks++; if (pslverr_m !== 1'b0) begin errs++; $display("FAIL reset_pslverr: got %b expected 0", pslverr_m); end
    checks++; if (prdata_m !== 32'h0) begin errs++; $display("FAIL reset_prdata: got %h expected 0", prdata_m); end
    checks++; if (err_cnt_m !== 16'h0) begin errs++; $display("FAIL reset_err_cnt: got %h expected 0", err_cnt_m); end
    sys_aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int n;
    bit st;
    dsel = 2'd0;
    do_reset();
    model_xfer(1'b1, 32'h10, 32'hDEADBEEF, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, rd, err, n, st);
    checks++; if (n !== 1) begin errs++; $display("FAIL zw_write_latency: got %0d expected 1", n); end
    checks++; if (err !== exp_err) begin errs++; $display("FAIL zw_write_err: got %b expected %b", err, exp_err); end
    checks++; if (st !== 1'b0) begin errs++; $display("FAIL zw_write_stray: got %b expected 0", st); end
    model_xfer(1'b0, 32'h10, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, err, n, st);
    checks++; if (n !== 1) begin errs++; $display("FAIL zw_read_latency: got %0d expected 1", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL zw_read_data: got %h expected deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL zw_read_err: got %b expected 0", err); end
  endtask

  task automatic test_wait3();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int n;
    bit st;
    dsel = 2'd1;
    do_reset();
    model_xfer(1'b0, 32'h0, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, n, st);
    checks++; if (n !== 4) begin errs++; $display("FAIL w3_latency: got %0d expected 4", n); end
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL w3_read_data: got %h expected %h", rd, exp_rd); end
    checks++; if (st !== 1'b0) begin errs++; $display("FAIL w3_stray: got %b expected 0", st); end
    model_xfer(1'b1, 32'h3C, 32'h0BADF00D, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h3C, 32'h0BADF00D, rd, err, n, st);
    model_xfer(1'b0, 32'h3C, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h3C, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL w3_rw_data: got %h expected %h", rd, exp_rd); end
    checks++; if (n !== 4) begin errs++; $display("FAIL w3_rw_latency: got %0d expected 4", n); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int n;
    bit st;
    dsel = 2'd0;
    do_reset();
    model_xfer(1'b1, 32'h0, 32'h11112222, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h0, 32'h11112222, rd, err, n, st);
    model_xfer(1'b1, 32'h100, 32'h12345678, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h100, 32'h12345678, rd, err, n, st);
    checks++; if (err !== exp_err) begin errs++; $display("FAIL oob_write_err: got %b expected %b", err, exp_err); end
    model_xfer(1'b0, 32'h100, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h100, 32'h0, rd, err, n, st);
    checks++; if (err !== exp_err) begin errs++; $display("FAIL oob_read_err: got %b expected %b", err, exp_err); end
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL oob_read_data: got %h expected %h", rd, exp_rd); end
    checks++; if (err_cnt_m !== 16'(err_m)) begin errs++; $display("FAIL oob_err_cnt: got %0d expected %0d", err_cnt_m, err_m); end
    model_xfer(1'b0, 32'h0, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL oob_word0_kept: got %h expected %h", rd, exp_rd); end
    model_xfer(1'b1, 32'h05, 32'hA5A5A5A5, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h05, 32'hA5A5A5A5, rd, err, n, st);
    checks++; if (err !== exp_err) begin errs++; $display("FAIL misalign_err: got %b expected %b", err, exp_err); end
    model_xfer(1'b0, 32'h04, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h04, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd || err !== exp_err) begin errs++; $display("FAIL misalign_read: got %h/%b expected %h/%b", rd, err, exp_rd, exp_err); end
    checks++; if (err_cnt_m !== 16'(err_m)) begin errs++; $display("FAIL misalign_err_cnt: got %0d expected %0d", err_cnt_m, err_m); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, exp_rd, a;
    logic err, exp_err;
    int n;
    bit st, seen;
    dsel = 2'd2;
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 32'h0C : 32'h101;
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = 32'hCAFE0000 + 32'(k);
      tick();
      penable = 1'b1;
      tick();
      psel_b = 1'b0; penable = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (pready_m !== 1'b0) seen = 1'b1;
      end
    end
    checks++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_pready: got %b expected 0", seen); end
    checks++; if (err_cnt_m !== 16'h0) begin errs++; $display("FAIL abort_err_cnt: got %0d expected 0", err_cnt_m); end
    model_xfer(1'b0, 32'h0C, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h0C, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL abort_no_write: got %h expected %h", rd, exp_rd); end
    checks++; if (n !== 6) begin errs++; $display("FAIL abort_next_latency: got %0d expected 6", n); end
  endtask

  task automatic test_ignore_access();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int n;
    bit st, seen;
    dsel = 2'd0;
    do_reset();
    seen = 1'b0;
    psel_b = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h55;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (pready_m !== 1'b0) seen = 1'b1;
    end
    psel_b = 1'b0; penable = 1'b0;
    tick();
    if (pready_m !== 1'b0) seen = 1'b1;
    checks++; if (seen !== 1'b0) begin errs++; $display("FAIL ignore_pready: got %b expected 0", seen); end
    model_xfer(1'b0, 32'h20, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h20, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL ignore_no_write: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int n;
    bit st;
    dsel = 2'd2;
    do_reset();
    model_xfer(1'b1, 32'h0C, 32'h77, exp_rd, exp_err);
    apb_xfer(1'b1, 32'h0C, 32'h77, rd, err, n, st);
    checks++; if (n !== 6) begin errs++; $display("FAIL w5_latency: got %0d expected 6", n); end
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1;
    tick();
    penable = 1'b1;
    tick();
    sys_aresetn = 1'b0;
    #1;
    checks++; if (pready_m !== 1'b0 || prdata_m !== 32'h0) begin errs++; $display("FAIL midrst_outputs: got %b/%h expected 0/0", pready_m, prdata_m); end
    psel_b = 1'b0; penable = 1'b0;
    tick();
    tick();
    sys_aresetn = 1'b1;
    model_reset();
    model_xfer(1'b0, 32'h08, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h08, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL midrst_no_commit: got %h expected %h", rd, exp_rd); end
    checks++; if (n !== 6) begin errs++; $display("FAIL midrst_first_setup: got %0d expected 6", n); end
    model_xfer(1'b0, 32'h0C, 32'h0, exp_rd, exp_err);
    apb_xfer(1'b0, 32'h0C, 32'h0, rd, err, n, st);
    checks++; if (rd !== exp_rd) begin errs++; $display("FAIL midrst_array_clear: got %h expected %h", rd, exp_rd); end
    checks++; if (err_cnt_m !== 16'h0) begin errs++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt_m); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp_rd, wa, ra, wd;
    logic err, exp_err;
    int n;
    bit st;
    int unsigned t0, widx;
    dsel = 2'd0;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      widx = $urandom_range(0, 63);
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       wa = 32'($urandom_range(64, 255)) * 32'd4;
        1:       wa = widx * 32'd4 + 32'($urandom_range(1, 3));
        default: wa = widx * 32'd4;
      endcase
      model_xfer(1'b1, wa, wd, exp_rd, exp_err);
      apb_xfer(1'b1, wa, wd, rd, err, n, st);
      checks++; if (err !== exp_err || n !== 1) begin errs++; $display("FAIL b2b_write[%0d]: got err=%b lat=%0d expected err=%b lat=1", i, err, n, exp_err); end
      ra = ($urandom_range(0, 3) == 0) ? widx * 32'd4 : 32'($urandom_range(0, 63)) * 32'd4;
      model_xfer(1'b0, ra, 32'h0, exp_rd, exp_err);
      apb_xfer(1'b0, ra, 32'h0, rd, err, n, st);
      checks++; if (rd !== exp_rd || err !== exp_err || n !== 1 || st !== 1'b0) begin errs++; $display("FAIL b2b_read[%0d] addr %h: got %h err=%b lat=%0d expected %h err=%b lat=1", i, ra, rd, err, n, exp_rd, exp_err); end
    end
    checks++; if (cyc - t0 !== 32'd400) begin errs++; $display("FAIL b2b_cycles: got %0d expected 400", cyc - t0); end
    checks++; if (err_cnt_m !== 16'(err_m)) begin errs++; $display("FAIL b2b_err_cnt: got %0d expected %0d", err_cnt_m, err_m); end
  endtask

  task automatic test_back_to_back_wait();
    logic [31:0] rd, exp_rd, a, wd;
    logic err, exp_err;
    int n;
    bit st;
    int unsigned t0;
    dsel = 2'd1;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, 63)) * 32'd4;
      wd = $urandom;
      model_xfer(1'b1, a, wd, exp_rd, exp_err);
      apb_xfer(1'b1, a, wd, rd, err, n, st);
      model_xfer(1'b0, a, 32'h0, exp_rd, exp_err);
      apb_xfer(1'b0, a, 32'h0, rd, err, n, st);
      checks++; if (rd !== exp_rd || n !== 4) begin errs++; $display("FAIL b2bw_read[%0d]: got %h lat=%0d expected %h lat=4", i, rd, n, exp_rd); end
    end
    checks++; if (cyc - t0 !== 32'd80) begin errs++; $display("FAIL b2bw_cycles: got %0d expected 80", cyc - t0); end
  endtask

  initial begin
    tick();
    test_reset();
    test_zero_wait();
    test_wait3();
    test_errors();
    test_abort();
    test_ignore_access();
    test_reset_mid();
    test_back_to_back();
    test_back_to_back_wait();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL take parameters: AW_APB, default `AW_APB, APB address width; DW_APB, default `DW_APB (32), data width; DEPTH, default 64, number of words; WAIT_CYCLES, default 0, range 0..15, wait states per access.
REQ-002 SHALL have port apb_clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port sys_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port s_apb  apb_ifc slave modport  --  psel, penable, pwrite, paddr[AW_APB], pwdata[DW_APB] in; pready, prdata[DW_APB], pslverr out.
REQ-005 SHALL have port err_cnt  out  16  count of completed transfers with pslverr, saturating at 16'hFFFF.

Function
REQ-006 SHALL hold DEPTH words of DW_APB bits; word index = paddr >> 2 (byte addressing).
REQ-007 SHALL use FSM states IDLE, WAIT, RESP.
REQ-008 IDLE: on sampled psel & ~penable (setup phase), SHALL latch paddr, pwrite, pwdata, load wait counter with WAIT_CYCLES; go RESP if WAIT_CYCLES==0, else WAIT.
REQ-009 WAIT: SHALL decrement counter each cycle; when counter reaches 1 and psel & penable, go RESP.
REQ-010 pready SHALL be registered, high only in RESP, for exactly one cycle; RESP always returns to IDLE.
REQ-011 Latency: pready SHALL be high in access cycle WAIT_CYCLES+1, counted from the first penable cycle; zero-wait gives pready in the first access cycle.
REQ-012 Write SHALL commit to the array at the edge ending the RESP cycle, only if pslverr is 0.
REQ-013 Read: prdata SHALL equal the array word at the latched index during RESP; prdata SHALL be 0 in every other cycle.
REQ-014 pslverr SHALL be high only in RESP, and only when index >= DEPTH or paddr[1:0] != 0; an erroring read returns prdata 0.
REQ-015 err_cnt SHALL increment by 1 at the end of each RESP cycle with pslverr high, and hold at 16'hFFFF.
REQ-016 Abort: psel low while in WAIT SHALL return the FSM to IDLE; no pready, no write, no err_cnt change.
REQ-017 Back-to-back: a setup phase in the cycle right after RESP SHALL be accepted without an extra idle cycle.
REQ-018 Write-then-read of the same address back-to-back SHALL return the newly written data.
REQ-019 psel & penable sampled in IDLE without a preceding setup phase SHALL be ignored.

Reset
REQ-020 sys_aresetn low SHALL immediately force: FSM IDLE, pready 0, pslverr 0, prdata 0, err_cnt 0, wait counter 0, all array words 0.
REQ-021 Reset during WAIT or RESP SHALL abandon the transfer; a pending write SHALL NOT commit.
REQ-022 After reset release, the first setup phase SHALL be accepted on the first rising edge.

Structure
REQ-023 Package apb_slave_pkg SHALL hold the state enum (IDLE, WAIT, RESP), ADDR_LSB = 2 and WAIT_CNT_W = 4.
REQ-024 The array SHALL be sub-module apb_regfile_mem: 1 write port, 1 combinational read port, async clear; the FSM, counter, error check and err_cnt stay in apb_slave_regfile.
REQ-025 Widths SHALL come from `AW_APB / `DW_APB in axilite_to_apb_define.svh.

Verification
REQ-026 WAIT_CYCLES=0: write 0xDEADBEEF to paddr 0x10, then read 0x10 -> pready in first access cycle both times; prdata 0xDEADBEEF; pslverr 0.
REQ-027 WAIT_CYCLES=3: read paddr 0x0 after reset -> pready low for 3 access cycles, high in the 4th; prdata 0x0.
REQ-028 Write 0x12345678 to paddr 0x100 (index 64, DEPTH 64), then read 0x100 -> pslverr 1 on both; prdata 0; err_cnt = 2; word 0 unchanged.
REQ-029 Write 0xA5A5A5A5 to misaligned paddr 0x05 -> pslverr 1; read 0x04 returns 0.
REQ-030 WAIT_CYCLES=5: start write 0x1 to 0x08, assert sys_aresetn low in the 2nd access cycle, release, read 0x08 -> 0x0, err_cnt 0.
REQ-031 100 back-to-back random writes, each followed by a read of indices 0..63, checked against a scoreboard -> all match, no idle cycle inserted.
